// File: rtl/tmds_pkg.sv
// Purpose : shared TMDS receive definitions (control tokens, aligner states, word decode helpers).
// Latency : n/a (constants and pure functions only).
// Backpressure : n/a.
package tmds_pkg;

   // Control tokens, bit 0 is the first serial bit
   localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
   localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
   localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
   localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } align_state_t;

   // Undo the optional inversion (q[9]), then undo the XOR/XNOR chain (q[8])
   function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] o;
      d    = q[9] ? ~q[7:0] : q[7:0];
      o    = '0;
      o[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return o;
   endfunction

   function automatic logic tmds_is_token(input logic [9:0] q);
      return (q == TMDS_CTRL_00) || (q == TMDS_CTRL_01) ||
             (q == TMDS_CTRL_10) || (q == TMDS_CTRL_11);
   endfunction

   // Only meaningful when tmds_is_token(q) is true
   function automatic logic [1:0] tmds_token_ctrl(input logic [9:0] q);
      logic [1:0] c;
      case (q)
         TMDS_CTRL_01: c = 2'b01;
         TMDS_CTRL_10: c = 2'b10;
         TMDS_CTRL_11: c = 2'b11;
         default:      c = 2'b00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tmds_channel_decoder_word_decode.sv
// Purpose : stage-2 register turning one aligned word into {de, data, ctrl}, zeroed when not enabled.
// Latency : 1 cycle from word/is_token/enable to outputs.
// Backpressure : none; accepts a word every cycle.
// Ports: clk, rst_n (async, active low); word/is_token from stage 1; enable = aligner locked next cycle;
//        de/data/ctrl registered decode results (ctrl holds across data words).
module tmds_word_decode
   import tmds_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] word,
   input  logic       is_token,
   input  logic       enable,
   output logic       de,
   output logic [7:0] data,
   output logic [1:0] ctrl
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de   <= 1'b0;
         data <= 8'h00;
         ctrl <= 2'b00;
      end else if (!enable) begin
         de   <= 1'b0;
         data <= 8'h00;
         ctrl <= 2'b00;
      end else if (is_token) begin
         de   <= 1'b0;
         data <= 8'h00;
         ctrl <= tmds_token_ctrl(word);
      end else begin
         de   <= 1'b1;
         data <= tmds_decode_data(word);
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Purpose : one TMDS receive channel: word alignment by bit-slip search, then pixel/control decode.
// Latency : word sampled on edge k appears on o_de/o_data/o_ctrl (and o_locked) one edge after its stage-1 capture.
// Backpressure : none; one word per pixel clock, o_bitslip is a 1-cycle request to the deserializer.
// Ports: i_pix_clk, i_rst_n (async, active low), i_tmds_word (bit 0 first serial bit);
//        o_bitslip, o_locked, o_de, o_data[7:0], o_ctrl[1:0] all registered.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN_MIN = 32,
   parameter int SEARCH_LEN   = 1024,
   parameter int SLIP_WAIT    = 16
) (
   input  logic       i_pix_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_tmds_word,
   output logic       o_bitslip,
   output logic       o_locked,
   output logic       o_de,
   output logic [7:0] o_data,
   output logic [1:0] o_ctrl
);

   localparam int RUN_W  = $clog2(CTRL_RUN_MIN + 1);
   localparam int GAP_W  = $clog2(SEARCH_LEN + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN_MIN - 1);
   localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(CTRL_RUN_MIN);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SEARCH_LEN - 1);
   localparam logic [WAIT_W-1:0] WAIT_FULL = WAIT_W'(SLIP_WAIT);

   // Stage 1: raw word plus token flag
   logic [9:0] word_q;
   logic       tok_q;

   align_state_t      state, state_nxt;
   logic [RUN_W-1:0]  run_cnt, run_nxt;
   logic [GAP_W-1:0]  gap_cnt, gap_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              slip_nxt;

   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         word_q <= '0;
         tok_q  <= 1'b0;
      end else begin
         word_q <= i_tmds_word;
         tok_q  <= tmds_is_token(i_tmds_word);
      end
   end

   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_SEARCH;
         run_cnt   <= '0;
         gap_cnt   <= '0;
         wait_cnt  <= '0;
         o_bitslip <= 1'b0;
         o_locked  <= 1'b0;
      end else begin
         state     <= state_nxt;
         run_cnt   <= run_nxt;
         gap_cnt   <= gap_nxt;
         wait_cnt  <= wait_nxt;
         o_bitslip <= slip_nxt;
         o_locked  <= (state_nxt == ST_LOCKED);
      end
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run_cnt;
      gap_nxt   = gap_cnt;
      wait_nxt  = wait_cnt;
      slip_nxt  = 1'b0;
      case (state)
         ST_SEARCH: begin
            if (tok_q) begin
               gap_nxt = '0;
               if (run_cnt >= RUN_LAST) begin
                  run_nxt   = RUN_FULL;
                  state_nxt = ST_LOCKED;
               end else begin
                  run_nxt = run_cnt + 1'b1;
               end
            end else begin
               run_nxt = '0;
               if (gap_cnt == GAP_LAST) begin
                  gap_nxt   = '0;
                  wait_nxt  = '0;
                  slip_nxt  = 1'b1;
                  state_nxt = ST_SLIP_WAIT;
               end else begin
                  gap_nxt = gap_cnt + 1'b1;
               end
            end
         end
         ST_SLIP_WAIT: begin
            // The word still in stage 1 on return predates the slip, so one
            // extra cycle is spent here before searching resumes.
            if (wait_cnt == WAIT_FULL) begin
               wait_nxt  = '0;
               run_nxt   = '0;
               gap_nxt   = '0;
               state_nxt = ST_SEARCH;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (tok_q) begin
               gap_nxt = '0;
            end else if (gap_cnt == GAP_LAST) begin
               // Lock lost: restart the search from clean counters, no slip
               run_nxt   = '0;
               gap_nxt   = '0;
               state_nxt = ST_SEARCH;
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         default: begin
            run_nxt   = '0;
            gap_nxt   = '0;
            wait_nxt  = '0;
            state_nxt = ST_SEARCH;
         end
      endcase
   end

   // Gate with the next state so the token completing the run is itself decoded
   tmds_word_decode u_word_decode (
      .clk      (i_pix_clk),
      .rst_n    (i_rst_n),
      .word     (word_q),
      .is_token (tok_q),
      .enable   (state_nxt == ST_LOCKED),
      .de       (o_de),
      .data     (o_data),
      .ctrl     (o_ctrl)
   );

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side decoder for one TMDS channel. Takes 10-bit parallel words from a per-channel deserializer in the pixel clock domain, aligns the word boundary with bit-slip requests, and decodes each aligned word into either an 8-bit pixel value with DE=1 or a 2-bit control token with DE=0. It is the mirror of the DVI/HDMI transmit path: three instances (B/G/R, channel 0 carries HSYNC/VSYNC) rebuild the RGB, sync and DE stream that `simple_480p` produces on the transmit side.

## Interface
Parameters:
- CTRL_RUN_MIN, 32: consecutive control tokens required to declare lock.
- SEARCH_LEN, 1024: words without any control token before a slip (search) or a lock loss (locked). Must exceed one line length; a 480p line is 858 pixels.
- SLIP_WAIT, 16: cycles to hold off after a bit-slip pulse, giving the deserializer time to settle.

Ports:
- i_pix_clk, in, 1: pixel clock (27 MHz for 480p); the only clock.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_tmds_word, in, 10: deserialized word; bit 0 is the first serial bit.
- o_bitslip, out, 1: one-cycle pulse asking the deserializer to shift the word boundary by 1 bit.
- o_locked, out, 1: word alignment is valid.
- o_de, out, 1: data enable; 1 means o_data is valid.
- o_data, out, 8: decoded pixel byte.
- o_ctrl, out, 2: {c1,c0} from the last control token; on channel 0 this is {vsync,hsync}.

## Operation
- **Token detection.** A word is a control token if it equals one of:
  - 10'h354 → ctrl 00
  - 10'h0AB → ctrl 01
  - 10'h154 → ctrl 10
  - 10'h2AB → ctrl 11
- **Data decode** (any non-token word):
  - d = q[9] ? ~q[7:0] : q[7:0]
  - out[0] = d[0]
  - out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7
- **FSM states:** SEARCH, SLIP_WAIT, LOCKED.
- **Counters:**
  - run_cnt: consecutive tokens; saturates at CTRL_RUN_MIN.
  - gap_cnt: words since the last token.
  - wait_cnt.
- **SEARCH:**
  - A token increments run_cnt and clears gap_cnt.
  - A non-token clears run_cnt and increments gap_cnt.
  - When run_cnt reaches CTRL_RUN_MIN, go to LOCKED.
  - When gap_cnt reaches SEARCH_LEN, pulse o_bitslip, clear the counters and go to SLIP_WAIT.
- **SLIP_WAIT:** count SLIP_WAIT cycles, ignoring input, then return to SEARCH with the counters cleared.
- **LOCKED:**
  - A token clears gap_cnt.
  - When gap_cnt reaches SEARCH_LEN, go to SEARCH (lock lost). No slip is issued on this transition.
  - The decoder does not leave LOCKED for any other reason, including an isolated odd word.
- **Outputs outside LOCKED:** o_de = 0, o_data = 0, o_ctrl = 0.
- **Outputs in LOCKED:**
  - Token: o_de = 0, o_ctrl = token value, o_data = 0.
  - Data word: o_de = 1, o_data = decoded byte, o_ctrl holds its last value.
- Simultaneous conditions cannot occur because the token and non-token paths are exclusive. A run that completes on the same cycle gap_cnt would expire cannot happen, since a token clears gap_cnt.

## Timing
- Reset value of every output is 0. Reset is asynchronous and returns the FSM to SEARCH with all counters at 0, including reset asserted mid-lock or mid-wait.
- **Pipeline:** two registers.
  - Stage 1: input word plus token flag.
  - Stage 2: decoded outputs.
  - A word presented at edge k appears on o_data/o_ctrl/o_de after edge k+2.
- **Lock:** o_locked rises at edge k+2 when the CTRL_RUN_MIN-th consecutive token is sampled at edge k. The first gated output is the word from that same edge.
- **Unlock:** o_locked falls 2 edges after the SEARCH_LEN-th token-free word is sampled. Outputs are forced to 0 on the same edge.
- **Slip:** o_bitslip is high for exactly 1 cycle. Slips are therefore spaced at least SEARCH_LEN + SLIP_WAIT + 1 cycles apart.
- All outputs are registered; no combinational path from input to output.

## Structure
- **Package tmds_pkg:**
  - Token constants: TMDS_CTRL_00/01/10/11.
  - FSM state encoding.
  - Function tmds_decode_data(q[9:0]) returning [7:0].
  - Function tmds_is_token().
- **Sub-module tmds_word_decode:** registered stage-2 decode of one word into {de, data, ctrl}.
- The FSM and counters live in tmds_channel_decoder.

## Test plan
1. **Reset:** assert i_rst_n = 0 mid-stream → all outputs 0 immediately; after release, o_locked = 0 until a fresh run of CTRL_RUN_MIN tokens.
2. **Lock on aligned tokens:** 40 × 10'h354 → o_locked = 1 two edges after the 32nd token; o_ctrl = 00, o_de = 0, no o_bitslip.
3. **Data decode while locked:**
   - 10'h100 → o_de = 1, o_data = 8'h00.
   - 10'h2FF → 8'hFE.
   - 10'h1FF → 8'h01.
   - Each appears 2 cycles after input.
   - Then 10'h2AB → o_de = 0, o_ctrl = 11.
4. **Alignment search:** the bench deserializer model starts 3 bits off and shifts 1 bit on each o_bitslip, feeding 480p lines (138 blanking tokens per line).
   - o_bitslip pulses are spaced at least SEARCH_LEN + SLIP_WAIT + 1 cycles apart.
   - Lock is reached after 7 slips.
   - Decoded pixels match the source.
5. **Lock loss:** once locked, feed SEARCH_LEN data-only words → o_locked falls, o_de = 0, no o_bitslip in that cycle. Tokens then relock.
6. **Broken run:** 31 tokens, one data word, 31 tokens → no lock. One more token (32 consecutive) → lock.
